// File: rtl/dcache_port_arbiter_if.sv
// rtl/dcache_port_arbiter_if.sv - requester-side request/response port of the dcache port arbiter
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 288
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_dat_w;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_dat;

    modport master (
        output req_valid, req_we, req_addr, req_dat_w,
        input  req_ready, rsp_valid, rsp_dat
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_dat_w,
        output req_ready, rsp_valid, rsp_dat
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - regfile/DMA arbiter for the dcache data array port with starvation guard and drain
module dcache_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 288,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dcache_port_arbiter_if.slave rf,
    dcache_port_arbiter_if.slave dma,
    input  logic              quiesce_req,
    output logic              quiesce_ack,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dat_w,
    input  logic [DATA_W-1:0] mem_dat_r
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {RUN, DRAIN, QUIET} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     starve;
    logic              grant_en;
    logic              dma_wins;
    logic              rf_hs, dma_hs;
    logic              issue_dma;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_d;
    logic              busy;

    assign rf_hs  = rf.req_valid  & rf.req_ready;
    assign dma_hs = dma.req_valid & dma.req_ready;
    assign busy   = mem_re | mem_we | (|pipe_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (quiesce_req) state_nxt = DRAIN;
            DRAIN:   if (!quiesce_req) state_nxt = RUN;
                     else if (!busy)   state_nxt = QUIET;
            QUIET:   if (!quiesce_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Ready is gated by rst_n so the ports read idle while reset is held.
    always_comb begin
        quiesce_ack   = (state == QUIET);
        grant_en      = rst_n && (state == RUN) && !quiesce_req;
        dma_wins      = dma.req_valid && (starve == SW'(STARVE_MAX));
        rf.req_ready  = grant_en && !dma_wins;
        dma.req_ready = grant_en && (dma_wins || !rf.req_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= '0;
        end else if (state == RUN) begin
            if (!dma.req_valid || dma_hs)
                starve <= '0;
            else if (starve != SW'(STARVE_MAX))
                starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_dat_w <= '0;
            issue_dma <= 1'b0;
            pipe_v    <= '0;
            pipe_d    <= '0;
        end else begin
            mem_re    <= (rf_hs & ~rf.req_we) | (dma_hs & ~dma.req_we);
            mem_we    <= (rf_hs &  rf.req_we) | (dma_hs &  dma.req_we);
            issue_dma <= dma_hs;
            if (rf_hs) begin
                mem_addr  <= rf.req_addr;
                mem_dat_w <= rf.req_dat_w;
            end else if (dma_hs) begin
                mem_addr  <= dma.req_addr;
                mem_dat_w <= dma.req_dat_w;
            end
            // Owner tag follows the read until the array data is due.
            pipe_v[0] <= mem_re;
            pipe_d[0] <= issue_dma;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign rf.rsp_valid  = pipe_v[RD_LAT-1] & ~pipe_d[RD_LAT-1];
    assign dma.rsp_valid = pipe_v[RD_LAT-1] &  pipe_d[RD_LAT-1];
    assign rf.rsp_dat    = rf.rsp_valid  ? mem_dat_r : '0;
    assign dma.rsp_dat   = dma.rsp_valid ? mem_dat_r : '0;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - scoreboard bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
    localparam int AW = 15;
    localparam int DW = 288;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rf_if ();
    dcache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

    logic          quiesce_req, quiesce_ack, mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat_w, mem_dat_r;

    dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n), .rf(rf_if), .dma(dma_if),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rsp_seen = 0;

    typedef struct { int cyc; logic [DW-1:0] dat; } exp_t;
    exp_t rf_q[$];
    exp_t dma_q[$];
    exp_t m_e;

    logic rf_hs, dma_hs;
    assign rf_hs  = rf_if.req_valid & rf_if.req_ready;
    assign dma_hs = dma_if.req_valid & dma_if.req_ready;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: preset contents unless overwritten, read data RD_LAT cycles after mem_re.
    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        case (a)
            8'h12:   return DW'('hABC);
            8'h20:   return DW'('h111);
            8'h21:   return DW'('h222);
            8'h22:   return DW'('h333);
            8'h30:   return DW'('h555);
            8'h31:   return DW'('h666);
            default: return DW'({a, 8'h5A});
        endcase
    endfunction

    bit            written [256];
    logic [DW-1:0] wdata   [256];
    logic [DW-1:0] rd0, rd1;
    always @(posedge clk) begin
        if (mem_we) begin
            written[mem_addr[7:0]] <= 1'b1;
            wdata[mem_addr[7:0]]   <= mem_dat_w;
        end
        rd0 <= !mem_re ? '0 : (written[mem_addr[7:0]] ? wdata[mem_addr[7:0]] : init_val(mem_addr[7:0]));
        rd1 <= rd0;
    end
    assign mem_dat_r = rd1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_if.rsp_valid) begin
                rsp_seen++;
                if (rf_q.size() == 0) chk("rf_rsp_unexpected", rf_if.rsp_valid, 0);
                else begin
                    m_e = rf_q.pop_front();
                    chk("rf_rsp_cyc", cyc, m_e.cyc);
                    chk("rf_rsp_dat", rf_if.rsp_dat, m_e.dat);
                end
            end
            if (dma_if.rsp_valid) begin
                rsp_seen++;
                if (dma_q.size() == 0) chk("dma_rsp_unexpected", dma_if.rsp_valid, 0);
                else begin
                    m_e = dma_q.pop_front();
                    chk("dma_rsp_cyc", cyc, m_e.cyc);
                    chk("dma_rsp_dat", dma_if.rsp_dat, m_e.dat);
                end
            end
            if (rf_if.req_valid && dma_if.req_valid) chk("one_grant", rf_hs & dma_hs, 0);
            if (mem_re || mem_we) chk("strobe_excl", mem_re & mem_we, 0);
        end
    end

    task automatic req(input bit is_dma, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp, output int hs);
        bit done;
        done = 0;
        hs = -1;
        if (is_dma) begin
            dma_if.req_valid = 1; dma_if.req_we = we; dma_if.req_addr = a; dma_if.req_dat_w = wd;
        end else begin
            rf_if.req_valid = 1; rf_if.req_we = we; rf_if.req_addr = a; rf_if.req_dat_w = wd;
        end
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (is_dma ? dma_if.req_ready : rf_if.req_ready) begin
                done = 1;
                hs = cyc;
                if (!we) begin
                    if (is_dma) dma_q.push_back('{cyc + 1 + RL, exp});
                    else        rf_q.push_back('{cyc + 1 + RL, exp});
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("req_timeout", DW'(done), 1);
        if (is_dma) dma_if.req_valid = 0;
        else        rf_if.req_valid = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, DW'(mem_addr), 0);
        chk({tag, "_mem_dat_w"}, mem_dat_w, 0);
        chk({tag, "_rf_ready"}, rf_if.req_ready, 0);
        chk({tag, "_dma_ready"}, dma_if.req_ready, 0);
        chk({tag, "_rsp_valid"}, {rf_if.rsp_valid, dma_if.rsp_valid}, 0);
        chk({tag, "_rsp_dat"}, rf_if.rsp_dat | dma_if.rsp_dat, 0);
        chk({tag, "_ack"}, quiesce_ack, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2;
        quiesce_req = 0;
        rf_if.req_valid = 0;  rf_if.req_we = 0;  rf_if.req_addr = '0;  rf_if.req_dat_w = '0;
        dma_if.req_valid = 0; dma_if.req_we = 0; dma_if.req_addr = '0; dma_if.req_dat_w = '0;
        #3;
        rf_if.req_valid = 1;
        dma_if.req_valid = 1;
        #1;
        check_idle("reset");
        rf_if.req_valid = 0;
        dma_if.req_valid = 0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // single rf read
        req(0, 0, 'h12, '0, 'hABC, t0);
        chk("t1_mem_re", mem_re, 1);
        chk("t1_mem_addr", DW'(mem_addr), 'h12);
        repeat (4) @(posedge clk);
        #1;

        // contention: dma forced every 9th cycle
        rf_if.req_valid = 1;  rf_if.req_we = 1;  rf_if.req_addr = 'h80;  rf_if.req_dat_w = 'h1;
        dma_if.req_valid = 1; dma_if.req_we = 1; dma_if.req_addr = 'h90; dma_if.req_dat_w = 'h2;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("t2_rf_grant", rf_hs, DW'(i % 9 != 0));
            chk("t2_dma_grant", dma_hs, DW'(i % 9 == 0));
            @(posedge clk);
            #1;
        end
        rf_if.req_valid = 0;
        dma_if.req_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        // interleaved back-to-back reads
        req(0, 0, 'h20, '0, 'h111, t0);
        req(1, 0, 'h21, '0, 'h222, t1);
        req(0, 0, 'h22, '0, 'h333, t2);
        chk("t3_hs1", t1, t0 + 1);
        chk("t3_hs2", t2, t0 + 2);
        repeat (6) @(posedge clk);
        #1;

        // dma write then rf read of the same address
        req(1, 1, 'h40, 'h155, '0, t0);
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_addr", DW'(mem_addr), 'h40);
        chk("t4_mem_dat_w", mem_dat_w, 'h155);
        req(0, 0, 'h40, '0, 'h155, t1);
        chk("t4_mem_re", mem_re, 1);
        chk("t4_hs", t1, t0 + 1);
        repeat (6) @(posedge clk);
        #1;

        // quiesce with two reads in flight
        req(0, 0, 'h30, '0, 'h555, t0);
        req(1, 0, 'h31, '0, 'h666, t1);
        quiesce_req = 1;
        rf_if.req_valid = 1; rf_if.req_we = 0; rf_if.req_addr = 'h30;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            chk("t5_rf_ready", rf_if.req_ready, 0);
            chk("t5_ack", quiesce_ack, DW'(c == 6));
            if (c < 6) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1 quiesce_req = 0;
        @(negedge clk);
        chk("t5_ack_hold", quiesce_ack, 1);
        chk("t5_ready_hold", rf_if.req_ready, 0);
        @(posedge clk);
        #1;
        chk("t5_ack_drop", quiesce_ack, 0);
        chk("t5_ready_back", rf_if.req_ready, 1);
        req(0, 0, 'h30, '0, 'h555, t2);
        chk("t5_resume_cyc", t2, t0 + 8);
        repeat (5) @(posedge clk);
        #1 quiesce_req = 1;
        @(posedge clk);
        #1 chk("t5_empty_ack1", quiesce_ack, 0);
        @(posedge clk);
        #1 chk("t5_empty_ack2", quiesce_ack, 1);
        quiesce_req = 0;
        @(posedge clk);
        #1 chk("t5_empty_ack3", quiesce_ack, 0);

        // reset with reads in flight
        req(0, 0, 'h12, '0, 'hABC, t0);
        req(1, 0, 'h20, '0, 'h111, t1);
        rf_q.delete();
        dma_q.delete();
        rsp_seen = 0;
        #2 rst_n = 0;
        #1 check_idle("t6");
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1;
        repeat (8) @(posedge clk);
        #1 chk("t6_no_rsp", rsp_seen, 0);

        chk("rf_q_empty", rf_q.size(), 0);
        chk("dma_q_empty", dma_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
